// File: rtl/numa_bank_adapter_if.sv
// rtl/numa_bank_adapter_if.sv - interconnect-side request/response bundle for one memory bank
interface numa_bank_adapter_if #(
  parameter int NumIn        = 32,
  parameter int DataWidth    = 32,
  parameter int AddrMemWidth = 12
);
  localparam int IdxW    = $clog2(NumIn);
  localparam int BeWidth = DataWidth / 8;

  logic                    req_i;
  logic [IdxW-1:0]         idx_i;
  logic [AddrMemWidth-1:0] add_i;
  logic                    wen_i;
  logic [DataWidth-1:0]    wdata_i;
  logic [BeWidth-1:0]      be_i;
  logic                    gnt_o;
  logic                    vld_o;
  logic [IdxW-1:0]         idx_o;
  logic [DataWidth-1:0]    rdata_o;

  modport master (
    output req_i, idx_i, add_i, wen_i, wdata_i, be_i,
    input  gnt_o, vld_o, idx_o, rdata_o
  );

  modport slave (
    input  req_i, idx_i, add_i, wen_i, wdata_i, be_i,
    output gnt_o, vld_o, idx_o, rdata_o
  );
endinterface

// File: rtl/numa_bank_adapter.sv
// rtl/numa_bank_adapter.sv - single-bank SRAM adapter: grant, fixed-latency response pipe, access counters
module numa_bank_adapter #(
  parameter int NumIn        = 32,
  parameter int DataWidth    = 32,
  parameter int BeWidth      = DataWidth / 8,
  parameter int AddrMemWidth = 12,
  parameter int MemLatency   = 1,
  parameter bit WriteRespOn  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  numa_bank_adapter_if.slave      bus,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddrMemWidth-1:0] mem_add_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [BeWidth-1:0]      mem_be_o,
  input  logic [DataWidth-1:0]    mem_rdata_i,
  input  logic                    stall_i,
  input  logic                    clr_i,
  output logic [31:0]             rd_cnt_o,
  output logic [31:0]             wr_cnt_o
);
  localparam int IdxW = $clog2(NumIn);

  if (MemLatency < 1 || MemLatency > 4) begin : g_bad_latency
    $fatal(1, "numa_bank_adapter: MemLatency must be within 1..4");
  end

  logic acc;

  assign bus.gnt_o   = bus.req_i & ~stall_i;
  assign acc         = bus.req_i & bus.gnt_o;
  assign mem_req_o   = acc;
  assign mem_we_o    = bus.wen_i;
  assign mem_add_o   = bus.add_i;
  assign mem_wdata_o = bus.wdata_i;
  assign mem_be_o    = bus.be_i;

  // Response pipe mirrors the SRAM latency; it never stalls, so responses leave in issue order.
  logic [MemLatency-1:0] vld_q;
  logic [MemLatency-1:0] wen_q;
  logic [IdxW-1:0]       idx_q [MemLatency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      wen_q <= '0;
      for (int i = 0; i < MemLatency; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= acc & (~bus.wen_i | WriteRespOn);
      wen_q[0] <= bus.wen_i;
      idx_q[0] <= bus.idx_i;
      for (int i = 1; i < MemLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        wen_q[i] <= wen_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign bus.vld_o   = vld_q[MemLatency-1];
  assign bus.idx_o   = idx_q[MemLatency-1];
  assign bus.rdata_o = (vld_q[MemLatency-1] && !wen_q[MemLatency-1]) ? mem_rdata_i : '0;

  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (clr_i) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (acc && !bus.wen_i && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_d = rd_cnt_q + 32'd1;
      if (acc &&  bus.wen_i && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) assert (!$isunknown(bus.vld_o)) else $error("vld_o is X out of reset");
  end
`endif
endmodule

// File: doc/numa_bank_adapter.md
NUMA_BANK_ADAPTER -- requirements
Module: numa_bank_adapter

Interface
REQ-001 SHALL have parameter NumIn, 32, number of initiator ports; index width IdxW = $clog2(NumIn).
REQ-002 SHALL have parameter DataWidth, 32, data word width.
REQ-003 SHALL have parameter BeWidth, DataWidth/8, byte-enable width.
REQ-004 SHALL have parameter AddrMemWidth, 12, in-bank word address width.
REQ-005 SHALL have parameter MemLatency, 1, SRAM read latency in cycles; legal range 1..4.
REQ-006 SHALL have parameter WriteRespOn, 1'b1, 1: writes return a response; 0: writes are silent.
REQ-007 SHALL use one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-008 Ports, interconnect side: req_i in 1 request; idx_i in IdxW initiator index; add_i in AddrMemWidth word address; wen_i in 1 (1 store, 0 load); wdata_i in DataWidth; be_i in BeWidth; gnt_o out 1 grant; vld_o out 1 response valid; idx_o out IdxW response index; rdata_o out DataWidth response data.
REQ-009 Ports, SRAM side: mem_req_o out 1; mem_we_o out 1; mem_add_o out AddrMemWidth; mem_wdata_o out DataWidth; mem_be_o out BeWidth; mem_rdata_i in DataWidth, valid exactly MemLatency cycles after mem_req_o.
REQ-010 Ports, control: stall_i in 1 bank blocked for maintenance; clr_i in 1 synchronous counter clear; rd_cnt_o out 32 accepted-load count; wr_cnt_o out 32 accepted-store count.

Function
REQ-011 gnt_o SHALL equal req_i & ~stall_i, combinationally; an accepted request is req_i & gnt_o.
REQ-012 mem_req_o SHALL equal the accepted request; mem_we_o, mem_add_o, mem_wdata_o, mem_be_o SHALL pass wen_i, add_i, wdata_i, be_i unmodified in the same cycle.
REQ-013 SHALL track each accepted request in a MemLatency-deep shift pipeline holding {valid, idx, wen}; one stage advances per cycle unconditionally, with no backpressure.
REQ-014 A stage SHALL be marked valid on entry only if the request is a load, or a store with WriteRespOn=1.
REQ-015 vld_o SHALL be 1 exactly MemLatency cycles after an accepted request marked valid; idx_o SHALL equal the request's idx_i.
REQ-016 rdata_o SHALL equal mem_rdata_i for load responses and SHALL be all zeros for write responses.
REQ-017 Back-to-back accepted requests, one per cycle, SHALL produce responses one per cycle, in order, without bubbles.
REQ-018 With stall_i=1, SHALL accept no new request; in-flight stages SHALL still drain and respond on schedule.
REQ-019 rd_cnt_o SHALL increment by 1 per accepted load, and wr_cnt_o by 1 per accepted store; each SHALL saturate at 32'hFFFF_FFFF and not wrap.
REQ-020 clr_i SHALL zero both counters on the next edge; clr_i has priority over an increment in the same cycle.
REQ-021 If MemLatency is outside 1..4, SHALL raise $fatal at elaboration (non-synthesis only).
REQ-022 (non-synthesis) SHALL assert that vld_o is never X after reset is released.

Reset
REQ-023 rst_ni low SHALL asynchronously clear all pipeline valid bits, idx and wen to 0, and both counters to 0.
REQ-024 During reset, vld_o, idx_o and rdata_o SHALL be 0; mem_req_o and gnt_o follow REQ-011/012 combinationally.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight responses; none SHALL appear after reset is released.

Verification
REQ-026 MemLatency=1: load at add 0x005 with idx 3, SRAM returns 0xDEADBEEF -> the next cycle has vld_o=1, idx_o=3, rdata_o=0xDEADBEEF; rd_cnt_o=1.
REQ-027 MemLatency=3, WriteRespOn=0: a store then a load (idx 1, 2) in consecutive cycles -> only one vld_o pulse, 3 cycles after the load, idx_o=2; wr_cnt_o=1, rd_cnt_o=1.
REQ-028 MemLatency=2: 8 back-to-back loads with idx 0..7 -> 8 consecutive vld_o cycles, idx_o 0..7 in order.
REQ-029 stall_i=1 with req_i=1 for 4 cycles -> gnt_o=0 and mem_req_o=0 throughout; an earlier in-flight load still responds on time.
REQ-030 Counter preloaded to 32'hFFFF_FFFE plus 3 loads -> rd_cnt_o holds 32'hFFFF_FFFF; clr_i together with a load -> counter reads 0.
REQ-031 MemLatency=4: reset pulsed 2 cycles after a load -> no vld_o is ever produced for that load.
